// File: rtl/aurora_tx_scheduler.sv
// rtl/aurora_tx_scheduler.sv - round-robin arbiter serializing 1034-bit DFX packets into 19 Aurora TX frames
//
// Ports:
//   clk, rst_n           system clock, synchronous active-low reset
//   req, req_data        per-requester request and flattened packets ([i*1034 +: 1034])
//   grant, done, busy    one-hot grant while sending, one-cycle done pulse, SEND indicator
//   tx_tdata/tvalid/tlast/tready  Aurora user TX stream
// Frame format: [63:9] 55-bit payload slice, [8] last, [7:5] winner index, [4:0] frame index.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration.
module aurora_tx_scheduler #(
    parameter int NUM_REQ           = 4,
    parameter int DATA_WIDTH        = 1024,
    parameter int ADDR_WIDTH        = 10,
    parameter int DATA_DFX_WIDTH    = DATA_WIDTH + ADDR_WIDTH,
    parameter int AURORA_DATA_WIDTH = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*DATA_DFX_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_REQ-1:0]                done,
    output logic                              busy,
    output logic [AURORA_DATA_WIDTH-1:0]      tx_tdata,
    output logic                              tx_tvalid,
    output logic                              tx_tlast,
    input  logic                              tx_tready
);

    localparam int PAY_W = 55;
    localparam logic [4:0] LAST_FRAME = 5'd18;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state;
    // Holds the not-yet-sent part of the packet; shifted down one slice per
    // accepted frame so the next payload is always in the low 55 bits.
    logic [DATA_DFX_WIDTH-1:0] shadow;
    logic [4:0]                frame_cnt;
    logic [2:0]                win_reg;
    logic [2:0]                pick;
    logic                      pick_ok;
    logic [DATA_DFX_WIDTH-1:0] pick_data;

`ifndef ARB_FIXED_PRIO_EN
    logic [2:0]                rr_ptr;
`endif

    function automatic logic [AURORA_DATA_WIDTH-1:0] build_frame(
        input logic [PAY_W-1:0] pay,
        input logic [2:0]       win,
        input logic [4:0]       idx
    );
        build_frame = {pay, (idx == LAST_FRAME), win, idx};
    endfunction

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        // Descending scan so the lowest set index is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = 3'(i);
                pick_ok = 1'b1;
            end
        end
    end
`else
    always_comb begin
        int idx;
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        // Scan from rr_ptr upward with wrap; first requester found wins.
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_ok && req[idx]) begin
                pick    = 3'(idx);
                pick_ok = 1'b1;
            end
        end
    end
`endif

    assign pick_data = req_data[int'(pick)*DATA_DFX_WIDTH +: DATA_DFX_WIDTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            frame_cnt <= '0;
            win_reg   <= '0;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            tx_tdata  <= '0;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr    <= '0;
`endif
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        shadow    <= pick_data >> PAY_W;
                        win_reg   <= pick;
                        grant     <= NUM_REQ'(1) << pick;
                        busy      <= 1'b1;
                        frame_cnt <= '0;
                        tx_tvalid <= 1'b1;
                        tx_tlast  <= 1'b0;
                        tx_tdata  <= build_frame(pick_data[PAY_W-1:0], pick, 5'd0);
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (tx_tvalid && tx_tready) begin
                        if (frame_cnt == LAST_FRAME) begin
                            tx_tvalid      <= 1'b0;
                            tx_tlast       <= 1'b0;
                            grant          <= '0;
                            busy           <= 1'b0;
                            done[win_reg]  <= 1'b1;
`ifndef ARB_FIXED_PRIO_EN
                            rr_ptr <= (win_reg == 3'(NUM_REQ - 1)) ? 3'd0 : win_reg + 3'd1;
`endif
                            state          <= IDLE;
                        end else begin
                            // Frame 18 naturally gets zeros in [63:53]: only
                            // 44 packet bits remain in the shifted shadow.
                            frame_cnt <= frame_cnt + 5'd1;
                            tx_tdata  <= build_frame(shadow[PAY_W-1:0], win_reg, frame_cnt + 5'd1);
                            tx_tlast  <= (frame_cnt + 5'd1 == LAST_FRAME);
                            shadow    <= shadow >> PAY_W;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aurora_tx_scheduler.sv
// tb/tb_aurora_tx_scheduler.sv - self-checking bench for aurora_tx_scheduler
module tb_aurora_tx_scheduler;

    localparam int NR = 4;
    localparam int PW = 1034;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*PW-1:0]  req_data;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic [63:0]       tx_tdata;
    logic              tx_tvalid;
    logic              tx_tlast;
    logic              tx_tready;

    int errors = 0;
    int checks = 0;

    aurora_tx_scheduler #(.NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .grant(grant), .done(done), .busy(busy),
        .tx_tdata(tx_tdata), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
        .tx_tready(tx_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_busy = 1'b0;
    logic [NR-1:0] m_done = '0;
    int            m_k    = 0;
    int            m_win  = 0;
    int            m_next = 0;
    logic [PW-1:0] m_snap = '0;

    function automatic int model_pick(input logic [NR-1:0] r, input int start);
        int s;
`ifdef ARB_FIXED_PRIO_EN
        s = 0;
`else
        s = start;
`endif
        for (int off = 0; off < NR; off++)
            if (r[(s + off) % NR]) return (s + off) % NR;
        return 0;
    endfunction

    function automatic logic [63:0] model_frame(input logic [PW-1:0] p, input int w, input int k);
        logic [54:0] pay;
        if (k < 18) pay = p[55*k +: 55];
        else        pay = {11'b0, p[1033:990]};
        return {pay, (k == 18), 3'(w), 5'(k)};
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = '0; m_k = 0; m_next = 0;
        end else begin
            m_done = '0;
            if (!m_busy) begin
                if (req != '0) begin
                    m_win  = model_pick(req, m_next);
                    m_snap = req_data[m_win*PW +: PW];
                    m_busy = 1'b1;
                    m_k    = 0;
                end
            end else if (tx_tready) begin
                if (m_k == 18) begin
                    m_busy = 1'b0;
                    m_done = NR'(1) << m_win;
                    m_next = (m_win + 1) % NR;
                end else begin
                    m_k++;
                end
            end
        end
    end

    // ---------------- compare / monitor process ----------------
    int            dut_acc = 0;
    int            grant_log[$];
    logic [NR-1:0] prev_grant = '0;

    always @(negedge clk) begin
        chk("tvalid", 64'(tx_tvalid), 64'(m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("grant", 64'(grant), m_busy ? 64'(NR'(1) << m_win) : 64'd0);
        chk("done", 64'(done), 64'(m_done));
        if (m_busy) begin
            chk("tdata", tx_tdata, model_frame(m_snap, m_win, m_k));
            chk("tlast", 64'(tx_tlast), 64'(m_k == 18));
        end
        if (tx_tvalid && tx_tready) begin
            chk("hdr_idx_seq", 64'(tx_tdata[4:0]), 64'(dut_acc));
            dut_acc++;
        end
        if (done != '0) begin
            chk("frames_per_pkt", 64'(dut_acc), 64'd19);
            dut_acc = 0;
        end
        if (!rst_n) dut_acc = 0;
        if (grant != '0 && prev_grant == '0)
            for (int i = 0; i < NR; i++) if (grant[i]) grant_log.push_back(i);
        prev_grant = grant;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0;
        tick();
        rst_n = 1'b1;
    endtask

    // Wait for n done pulses; bp selects tready pattern 1,0,0,1.
    task automatic wait_dones(input int n, input bit bp);
        int seen = 0;
        int cyc  = 0;
        while (seen < n && cyc < 600) begin
            if (bp) tx_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else    tx_tready = 1'b1;
            tick();
            cyc++;
            if (done != '0) seen++;
        end
        tx_tready = 1'b1;
        chk("done_timeout", 64'(seen), 64'(n));
    endtask

    task automatic wait_acc(input int n);
        int cyc = 0;
        while (dut_acc < n && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("acc_timeout", 64'(dut_acc), 64'(n));
    endtask

    function automatic logic [PW-1:0] byte_pattern();
        logic [PW-1:0] v;
        for (int b = 0; b < PW; b++) v[b] = 1'(((b / 8) % 256) >> (b % 8));
        return v;
    endfunction

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] v;
        for (int b = 0; b < PW; b++) v[b] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    int exp_log[$];

    initial begin
        rst_n = 1'b0; req = '0; req_data = '0; tx_tready = 1'b0;
        tick(); tick();
        chk("rst_tvalid", 64'(tx_tvalid), 64'd0);
        chk("rst_tdata", tx_tdata, 64'd0);
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tlast", 64'(tx_tlast), 64'd0);
        rst_n = 1'b1;
        tick();

        // Payload mapping
        req_data[0*PW +: PW] = byte_pattern();
        tx_tready = 1'b1;
        req = 4'b0001;
        tick();
        chk("frame0_lit", tx_tdata, 64'h0C0A080604020000);
        chk("frame0_grant", 64'(grant), 64'h1);
        while (!tx_tlast && dut_acc < 19) tick();
        chk("frame18_top", 64'(tx_tdata[63:53]), 64'd0);
        chk("frame18_hdr", 64'(tx_tdata[8:0]), 64'h112);
        chk("frame18_last", 64'(tx_tlast), 64'd1);
        tick();
        chk("done0_lit", 64'(done), 64'h1);
        chk("bubble_lit", 64'(tx_tvalid), 64'd0);
        tick();
        chk("regrant_lit", 64'(tx_tvalid), 64'd1);
        req = '0;
        wait_dones(1, 1'b0);

        // Backpressure
        req = 4'b0001;
        tick();
        req = '0;
        wait_dones(1, 1'b1);
        tick(); tick();

        // Round-robin, all requesting
        do_reset();
        for (int i = 1; i < NR; i++) req_data[i*PW +: PW] = rand_pkt();
        grant_log.delete();
        req = 4'b1111;
        wait_dones(4, 1'b0);
        wait_dones(1, 1'b0);
        req = '0;
        tick(); tick();
`ifdef ARB_FIXED_PRIO_EN
        exp_log = '{0, 0, 0, 0, 0};
`else
        exp_log = '{0, 1, 2, 3, 0};
`endif
        chk("rr_len", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk("rr_order", 64'(grant_log[i]), 64'(exp_log[i]));

        // Mid-packet request/data change
        req = 4'b0100;
        wait_acc(4);
        req = '0;
        req_data[2*PW +: PW] = ~req_data[2*PW +: PW];
        wait_dones(1, 1'b0);
        tick();

        // Reset mid-packet
        req = 4'b0001;
        wait_acc(10);
        rst_n = 1'b0;
        req = '0;
        tick();
        chk("rstmid_tvalid", 64'(tx_tvalid), 64'd0);
        chk("rstmid_grant", 64'(grant), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        req = 4'b0010;
        tick();
        chk("restart_grant", 64'(grant), 64'h2);
        chk("restart_hdr", 64'(tx_tdata[8:0]), 64'h020);
        req = '0;
        wait_dones(1, 1'b0);
        tick();

        // Requesters 1 and 3 held
        grant_log.delete();
        req = 4'b1010;
        wait_dones(3, 1'b0);
        req = 4'b1000;
        wait_dones(1, 1'b0);
        req = '0;
        tick(); tick();
`ifdef ARB_FIXED_PRIO_EN
        exp_log = '{1, 1, 1, 3};
`else
        exp_log = '{3, 1, 3, 3};
`endif
        chk("pair_len", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("pair_order", 64'(grant_log[i]), 64'(exp_log[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aurora_tx_scheduler.md
Name: aurora_tx_scheduler

Overview:
Round-robin scheduler that shares output port 0's Aurora TX link between NUM_REQ requesters, each presenting one DFX packet of 1034 bits (1024 data + 10 address). It latches the winning packet and serializes it into 19 64-bit frames: a 55-bit payload slice plus a 9-bit header, which is the framing the receive-side decapsulator reassembles. It sits between the per-port DFX packet buffers and the Aurora user TX AXI-stream interface.

Parameters:
NUM_REQ, 4, number of requesters (1..8).
DATA_WIDTH, 1024, DFX payload width.
ADDR_WIDTH, 10, DFX address width.
DATA_DFX_WIDTH, DATA_WIDTH+ADDR_WIDTH, packet width (1034).
AURORA_DATA_WIDTH, 64, TX frame width.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester packet-ready request
req_data  in  NUM_REQ*DATA_DFX_WIDTH  flattened packets; requester i occupies [i*1034 +: 1034]
grant  out  NUM_REQ  one-hot, high while that requester's packet is being sent
done  out  NUM_REQ  one-cycle pulse when requester i's last frame is accepted
busy  out  1  high in SEND
tx_tdata  out  AURORA_DATA_WIDTH  frame to Aurora
tx_tvalid  out  1  frame valid
tx_tlast  out  1  high on frame 18
tx_tready  in  1  Aurora accept

Behaviour:
- All outputs are registered. Synchronous reset drives grant=0, done=0, busy=0, tx_tdata=0, tx_tvalid=0, tx_tlast=0, rr_ptr=0, frame_cnt=0, and the state machine to IDLE.
- States are IDLE and SEND.
- IDLE: if req != 0, pick a winner by round-robin, searching from rr_ptr upward and wrapping. In the same edge:
  - copy the winner's req_data slice into a 1034-bit shadow register;
  - set grant one-hot, busy=1, frame_cnt=0, tx_tvalid=1 with frame 0;
  - go to SEND.
- Latency: req seen high in IDLE at edge N gives frame 0 valid from edge N.
- SEND: a frame is accepted on tx_tvalid && tx_tready. On acceptance frame_cnt increments and the next frame is loaded on the same edge, so back-to-back frames occur at one per cycle. While tx_tvalid && !tx_tready, tx_tdata and tx_tlast hold stable.
- Frame k, for k=0..17:
  - tx_tdata[63:9] = shadow[55k +: 55];
  - tx_tdata[8:0] = header.
- Frame 18:
  - tx_tdata[63:53] = 0;
  - tx_tdata[52:9] = shadow[1033:990];
  - tx_tlast = 1.
- Header bits: [8] last flag (1 only on frame 18), [7:5] winner index, [4:0] frame index 0..18. frame_cnt is 5 bits and never exceeds 18.
- Acceptance of frame 18:
  - tx_tvalid=0, tx_tlast=0, grant=0, busy=0;
  - done[winner]=1 for exactly one cycle;
  - rr_ptr = winner+1, wrapping modulo NUM_REQ;
  - return to IDLE.
- IDLE always lasts at least one cycle between packets, giving one bubble.
- The requester must hold req and req_data until its done pulse. Changes to req or req_data during SEND are ignored because the packet is sent from the shadow register. A winner that keeps req high after done is re-eligible, but only after higher-rotation requesters.
- A new req arriving in the same cycle as done is evaluated in the following IDLE cycle with the updated rr_ptr.
- Reset asserted mid-packet abandons the packet: tx_tvalid=0 after that edge and no done pulse. The frames already sent are not recalled; the receiver relies on tlast and the header.
- tx_tready high while tx_tvalid is low has no effect.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, with the lowest index winning. rr_ptr is not implemented and grant order is independent of history.
- Undefined (default): round-robin as described above.
- Framing, handshake and latency are identical in both builds.

Test Plan:
- Payload mapping: req=4'b0001, req_data[0] = 1034-bit pattern where byte j = j mod 256, tx_tready=1 → 19 frames on consecutive cycles; frame k payload equals slice 55k; frame 18 has [63:53]=0, header 9'h112, tx_tlast=1; done[0] pulses once; bubble cycle follows.
- Backpressure: same packet, tx_tready toggling 1,0,0,1 repeatedly → tx_tdata and tx_tlast stable during stalls, exactly 19 accepted frames, correct header index sequence 0..18.
- Round-robin: req=4'b1111 held continuously → grant order 0,1,2,3,0; each packet has 19 frames and header bits [7:5] match the grant.
- Mid-packet request change: req[2] deasserted and req_data[2] overwritten after frame 3 → remaining frames still carry the original shadow data and done[2] pulses.
- Reset mid-packet: rst_n low for one cycle at frame 10 → next cycle tx_tvalid=0, grant=0, no done pulse; after release, req=4'b0010 restarts at frame 0 for requester 1.
- ARB_FIXED_PRIO_EN defined: req=4'b1010 held continuously → requester 1 wins every packet; requester 3 is granted only once req[1] drops.
